// File: rtl/l2cache_pkg.sv
// Shared sizes and enumerations for the L2 tag SRAM controller and its arbiter.
package l2cache_pkg;

    localparam int unsigned          L2_TAG_ADDR_W = 9;
    localparam int unsigned          L2_TAG_W      = 20;
    localparam logic [L2_TAG_W-1:0]  L2_TAG_CLEAR  = 20'h00000;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } tag_ctrl_state_e;

    typedef enum logic {
        LOOKUP = 1'b0,
        UPDATE = 1'b1
    } arb_side_e;

endpackage

// File: rtl/l2cache_tag_rr_arb.sv
// Two-way round-robin arbiter: bit 0 = lookup, bit 1 = update.
// On contention the side not granted last wins; any grant records its side.
module l2cache_tag_rr_arb
    import l2cache_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    arb_side_e rr_last_q;
    arb_side_e rr_last_d;

    // Grant selection and last-winner update
    always_comb begin
        gnt       = 2'b00;
        rr_last_d = rr_last_q;
        if (en) begin
            case (req)
                2'b01: begin
                    gnt       = 2'b01;
                    rr_last_d = LOOKUP;
                end
                2'b10: begin
                    gnt       = 2'b10;
                    rr_last_d = UPDATE;
                end
                2'b11: begin
                    if (rr_last_q == LOOKUP) begin
                        gnt       = 2'b10;
                        rr_last_d = UPDATE;
                    end else begin
                        gnt       = 2'b01;
                        rr_last_d = LOOKUP;
                    end
                end
                default: begin
                    gnt       = 2'b00;
                    rr_last_d = rr_last_q;
                end
            endcase
        end else begin
            gnt       = 2'b00;
            rr_last_d = rr_last_q;
        end
    end

    // Last-winner register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_q <= LOOKUP;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/l2cache_tag_ctrl.sv
// Port sequencer for the single-port tag SRAM: clear sweep after reset/flush,
// then one arbitrated lookup or update per cycle.
module l2cache_tag_ctrl
    import l2cache_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = L2_TAG_ADDR_W,
    parameter int unsigned           DATA_WIDTH  = L2_TAG_W,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = L2_TAG_CLEAR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lk_req,
    input  logic [ADDR_WIDTH-1:0] lk_addr,
    output logic                  lk_gnt,
    output logic                  lk_rvalid,
    output logic [DATA_WIDTH-1:0] lk_rdata,
    input  logic                  up_req,
    input  logic [ADDR_WIDTH-1:0] up_addr,
    input  logic [DATA_WIDTH-1:0] up_wdata,
    output logic                  up_gnt,
    input  logic                  flush_req,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    tag_ctrl_state_e       state_q;
    tag_ctrl_state_e       state_d;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] ptr_d;
    logic                  lk_rvalid_q;
    logic                  arb_en_s;
    logic [1:0]            arb_gnt_s;

    // Flush takes priority over any pending request in the same cycle.
    assign arb_en_s = !rst && (state_q == RUN) && !flush_req;

    l2cache_tag_rr_arb u_arb (
        .clk (clk),
        .rst (rst),
        .req ({up_req, lk_req}),
        .en  (arb_en_s),
        .gnt (arb_gnt_s)
    );

    assign lk_gnt    = arb_gnt_s[0];
    assign up_gnt    = arb_gnt_s[1];
    assign init_done = !rst && (state_q == RUN);
    assign lk_rvalid = lk_rvalid_q;
    assign lk_rdata  = sram_dout0;

    // Next state, sweep pointer and SRAM port mux
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sram_csb0  = 1'b1;
        sram_web0  = 1'b1;
        sram_addr0 = PTR_ZERO;
        sram_din0  = DATA_ZERO;
        if (rst) begin
            state_d = CLEAR;
            ptr_d   = PTR_ZERO;
        end else begin
            case (state_q)
                CLEAR: begin
                    sram_csb0  = 1'b0;
                    sram_web0  = 1'b0;
                    sram_addr0 = ptr_q;
                    sram_din0  = CLEAR_VALUE;
                    ptr_d      = ptr_q + PTR_ONE;
                    if (ptr_q == PTR_LAST) begin
                        state_d = RUN;
                    end else begin
                        state_d = CLEAR;
                    end
                end
                RUN: begin
                    if (flush_req) begin
                        state_d = CLEAR;
                        ptr_d   = PTR_ZERO;
                    end else if (up_gnt) begin
                        sram_csb0  = 1'b0;
                        sram_web0  = 1'b0;
                        sram_addr0 = up_addr;
                        sram_din0  = up_wdata;
                    end else if (lk_gnt) begin
                        sram_csb0  = 1'b0;
                        sram_web0  = 1'b1;
                        sram_addr0 = lk_addr;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = CLEAR;
                    ptr_d   = PTR_ZERO;
                end
            endcase
        end
    end

    // Sequencer state, sweep pointer and read-valid registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CLEAR;
            ptr_q       <= PTR_ZERO;
            lk_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lk_rvalid_q <= lk_gnt;
        end
    end

endmodule

// File: tb/tb_l2cache_tag_ctrl.sv
// Directed bench for l2cache_tag_ctrl with a behavioural 512x20 1RW SRAM attached.
module tb_l2cache_tag_ctrl;

    logic        clk;
    logic        rst;
    logic        lk_req;
    logic [8:0]  lk_addr;
    logic        lk_gnt;
    logic        lk_rvalid;
    logic [19:0] lk_rdata;
    logic        up_req;
    logic [8:0]  up_addr;
    logic [19:0] up_wdata;
    logic        up_gnt;
    logic        flush_req;
    logic        init_done;
    logic        sram_csb0;
    logic        sram_web0;
    logic [8:0]  sram_addr0;
    logic [19:0] sram_din0;
    logic [19:0] sram_dout0;

    logic [19:0] mem [512];

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    l2cache_tag_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .lk_req     (lk_req),
        .lk_addr    (lk_addr),
        .lk_gnt     (lk_gnt),
        .lk_rvalid  (lk_rvalid),
        .lk_rdata   (lk_rdata),
        .up_req     (up_req),
        .up_addr    (up_addr),
        .up_wdata   (up_wdata),
        .up_gnt     (up_gnt),
        .flush_req  (flush_req),
        .init_done  (init_done),
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_dout0 (sram_dout0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: samples on posedge, read data appears after the edge.
    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0) mem[sram_addr0] <= sram_din0;
            else            sram_dout0      <= mem[sram_addr0];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] port_vec();
        return {30'h0, sram_csb0, sram_web0, sram_addr0, sram_din0, init_done, lk_gnt, up_gnt};
    endfunction

    function automatic logic [63:0] exp_vec(input logic csb, input logic web, input logic [8:0] addr,
                                            input logic [19:0] din, input logic idone,
                                            input logic lg, input logic ug);
        return {30'h0, csb, web, addr, din, idone, lg, ug};
    endfunction

    // Caller is at a negedge with inputs set; checks n sweep cycles from address 0.
    task automatic sweep(input string tag, input int n, input int flush_at);
        for (int i = 0; i < n; i++) begin
            if (i != 0) @(negedge clk);
            flush_req = (i == flush_at);
            #1;
            check(tag, port_vec(), exp_vec(1'b0, 1'b0, i[8:0], 20'h00000, 1'b0, 1'b0, 1'b0));
        end
        flush_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 20'h5A5A5 ^ 20'(i);
        sram_dout0 = 20'h00000;
        rst = 1'b1; flush_req = 1'b0;
        lk_req = 1'b0; lk_addr = 9'h000;
        up_req = 1'b0; up_addr = 9'h000; up_wdata = 20'h00000;

        // Reset values, with requests pending
        repeat (2) @(negedge clk);
        lk_req = 1'b1; up_req = 1'b1;
        #1;
        check("reset_port", port_vec(), exp_vec(1'b1, 1'b1, 9'h000, 20'h00000, 1'b0, 1'b0, 1'b0));
        check("reset_rvalid", lk_rvalid, 1'b0);
        lk_req = 1'b0; up_req = 1'b0;

        // Test 1: power-up sweep
        @(negedge clk); rst = 1'b0;
        sweep("t1_sweep", 512, -1);
        @(negedge clk); #1;
        check("t1_init_done", port_vec(), exp_vec(1'b1, 1'b1, 9'h000, 20'h00000, 1'b1, 1'b0, 1'b0));

        // Test 3: contention alternates UPD, LK, UPD, LK
        @(negedge clk);
        lk_req = 1'b1; lk_addr = 9'h003;
        up_req = 1'b1; up_addr = 9'h00A; up_wdata = 20'h12345;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            check("t3_up_gnt", up_gnt, (k % 2 == 0));
            check("t3_lk_gnt", lk_gnt, (k % 2 == 1));
            check("t3_rvalid", lk_rvalid, (k == 2));
        end
        @(negedge clk); lk_req = 1'b0; up_req = 1'b0; #1;
        check("t3_rvalid_last", lk_rvalid, 1'b1);
        check("t3_rdata_last", lk_rdata, 20'h00000);

        // Test 2: write then read back the same index
        @(negedge clk); up_req = 1'b1; up_addr = 9'h005; up_wdata = 20'hABCDE; #1;
        check("t2_up_port", port_vec(), exp_vec(1'b0, 1'b0, 9'h005, 20'hABCDE, 1'b1, 1'b0, 1'b1));
        @(negedge clk); up_req = 1'b0; lk_req = 1'b1; lk_addr = 9'h005; #1;
        check("t2_lk_port", port_vec(), exp_vec(1'b0, 1'b1, 9'h005, 20'h00000, 1'b1, 1'b1, 1'b0));
        @(negedge clk); lk_req = 1'b0; #1;
        check("t2_rvalid", lk_rvalid, 1'b1);
        check("t2_rdata", lk_rdata, 20'hABCDE);

        // Test 6: preload 0..7 with i+1, then 8 back-to-back lookups
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); up_req = 1'b1; up_addr = i[8:0]; up_wdata = 20'(i + 1); #1;
            check("t6_preload_gnt", up_gnt, 1'b1);
        end
        for (int j = 0; j < 8; j++) begin
            @(negedge clk); up_req = 1'b0; lk_req = 1'b1; lk_addr = j[8:0]; #1;
            check("t6_lk_gnt", lk_gnt, 1'b1);
            if (j > 0) begin
                check("t6_rvalid", lk_rvalid, 1'b1);
                check("t6_rdata", lk_rdata, 20'(j));
            end
        end
        @(negedge clk); lk_req = 1'b0; #1;
        check("t6_rvalid_last", lk_rvalid, 1'b1);
        check("t6_rdata_last", lk_rdata, 20'h00008);
        @(negedge clk); #1;
        check("t6_rvalid_idle", lk_rvalid, 1'b0);

        // Test 4: flush with a lookup pending; a second flush mid-sweep is ignored
        @(negedge clk); up_req = 1'b1; up_addr = 9'h1FF; up_wdata = 20'hFFFFF; #1;
        check("t4_up_gnt", up_gnt, 1'b1);
        @(negedge clk); up_req = 1'b0; lk_req = 1'b1; lk_addr = 9'h1FF; flush_req = 1'b1; #1;
        check("t4_flush_cycle", port_vec(), exp_vec(1'b1, 1'b1, 9'h000, 20'h00000, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        sweep("t4_sweep", 512, 100);
        @(negedge clk); #1;
        check("t4_lk_after", port_vec(), exp_vec(1'b0, 1'b1, 9'h1FF, 20'h00000, 1'b1, 1'b1, 1'b0));
        @(negedge clk); lk_req = 1'b0; #1;
        check("t4_rvalid", lk_rvalid, 1'b1);
        check("t4_rdata", lk_rdata, 20'h00000);

        // Test 5: reset drops an in-flight rvalid, then reset mid-sweep at ptr 200
        @(negedge clk); lk_req = 1'b1; lk_addr = 9'h005; #1;
        check("t5_lk_gnt", lk_gnt, 1'b1);
        @(posedge clk); #1;
        check("t5_rvalid_inflight", lk_rvalid, 1'b1);
        lk_req = 1'b0; rst = 1'b1; #1;
        check("t5_rst_rvalid", lk_rvalid, 1'b0);
        check("t5_rst_port_a", port_vec(), exp_vec(1'b1, 1'b1, 9'h000, 20'h00000, 1'b0, 1'b0, 1'b0));
        @(negedge clk); rst = 1'b0;
        sweep("t5_partial", 201, -1);
        rst = 1'b1; #1;
        check("t5_rst_port_b", port_vec(), exp_vec(1'b1, 1'b1, 9'h000, 20'h00000, 1'b0, 1'b0, 1'b0));
        @(negedge clk); rst = 1'b0;
        sweep("t5_sweep", 512, -1);
        @(negedge clk); #1;
        check("t5_init_done", port_vec(), exp_vec(1'b1, 1'b1, 9'h000, 20'h00000, 1'b1, 1'b0, 1'b0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
